avion_cpu_v2: RTL and testbench



---
 rtl/avion_pkg.sv | 38 +++
 rtl/avion_cpu_v2_if.sv | 21 ++
 rtl/avion_alu.sv | 59 +++++
 rtl/avion_cpu_v2.sv | 172 +++++++++++++++++
 tb/tb_avion_cpu_v2.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avion_pkg.sv
// avion_pkg: shared definitions for the avion_cpu_v2 accumulator core.
// Holds the 4-bit opcode map, the controller state encoding (also exported
// as a debug output of the top) and a helper that classifies opcodes that
// need a RAM operand read before they can complete.
package avion_pkg;

  localparam logic [3:0] OP_LOD = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JMZ = 4'd7;
  localparam logic [3:0] OP_NOP = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd9;
  localparam logic [3:0] OP_OR  = 4'd10;
  localparam logic [3:0] OP_JMN = 4'd11;
  localparam logic [3:0] OP_LDI = 4'd12;
  localparam logic [3:0] OP_SHL = 4'd13;
  localparam logic [3:0] OP_SHR = 4'd14;
  localparam logic [3:0] OP_ILL = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LATCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Opcodes 0..5 and OR address memory (STO writes it, the rest read it)
  // and therefore take the extra S_EXEC cycle.
  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode <= OP_AND) || (opcode == OP_OR);
  endfunction

endpackage

// File: rtl/avion_cpu_v2_if.sv
// avion_cpu_v2_if: single-port synchronous RAM bus between the CPU and blram.
//   MAR    : word address, driven by the CPU
//   MDRIn  : write data, driven by the CPU, 0 unless writing
//   RAMWr  : write strobe, driven by the CPU
//   MDROut : read data, driven by the RAM
// Protocol: there is no valid/ready pair. An address on MAR in cycle n
// yields its word on MDROut in cycle n+1 (one-cycle read latency). When
// RAMWr is high at a rising edge the RAM stores MDRIn at MAR on that edge;
// the CPU keeps RAMWr high for exactly one cycle per store.
interface avion_cpu_v2_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) ();
  logic [ADDRESS_WIDTH-1:0] MAR;
  logic [DATA_WIDTH-1:0]    MDRIn;
  logic                     RAMWr;
  logic [DATA_WIDTH-1:0]    MDROut;

  modport master (output MAR, output MDRIn, output RAMWr, input MDROut);
  modport slave  (input MAR, input MDRIn, input RAMWr, output MDROut);
endinterface

// File: rtl/avion_alu.sv
// avion_alu: combinational datapath of the accumulator core.
//   opcode     : current instruction opcode
//   acc        : accumulator value registered before the instruction
//   m          : RAM operand word, or the zero-extended operand for LDI
//   carry_in   : current carry flag
//   result     : new accumulator value (meaningful when writes_acc=1)
//   carry_out  : new carry (equals carry_in for ops that do not touch it)
//   zero       : result == 0
//   writes_acc : opcode updates ACC and the zero flag
module avion_alu
  import avion_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] m,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  zero,
  output logic                  writes_acc
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    sum        = {1'b0, acc} + {1'b0, m};
    // Top bit of the widened difference is the borrow.
    diff       = {1'b0, acc} - {1'b0, m};
    result     = acc;
    carry_out  = carry_in;
    writes_acc = 1'b0;
    case (opcode)
      OP_LOD: begin result = m; writes_acc = 1'b1; end
      OP_ADD: begin {carry_out, result} = sum; writes_acc = 1'b1; end
      OP_SUB: begin {carry_out, result} = diff; writes_acc = 1'b1; end
      // Product is sized by the result, so only the low word is kept.
      OP_MUL: begin result = acc * m; writes_acc = 1'b1; end
      OP_AND: begin result = acc & m; writes_acc = 1'b1; end
      OP_OR:  begin result = acc | m; writes_acc = 1'b1; end
      OP_LDI: begin result = m; writes_acc = 1'b1; end
      OP_SHL: begin
        result     = {acc[DATA_WIDTH-2:0], 1'b0};
        carry_out  = acc[DATA_WIDTH-1];
        writes_acc = 1'b1;
      end
      OP_SHR: begin
        result     = {1'b0, acc[DATA_WIDTH-1:1]};
        carry_out  = acc[0];
        writes_acc = 1'b1;
      end
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/avion_cpu_v2.sv
// avion_cpu_v2: parametrised accumulator CPU (FETCH/LATCH/DECODE/EXEC/HALT).
//   clk, rst : single clock, synchronous active-high reset
//   ram      : RAM bus (master side), one-cycle read latency
//   PC, ACC  : program counter and accumulator (registered)
//   zero     : ACC == 0 after the last ACC-writing op
//   carry    : carry/borrow of ADD/SUB, shifted-out bit of SHL/SHR
//   halted   : high while in S_HALT
//   error    : sticky, set by the illegal opcode
//   state    : controller state, for observation
// DATA_WIDTH must equal ADDRESS_WIDTH + 4: the top nibble of IR is the
// opcode and the low ADDRESS_WIDTH bits are the operand.
module avion_cpu_v2
  import avion_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  avion_cpu_v2_if.master           ram,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0]    ACC,
  output logic                     zero,
  output logic                     carry,
  output logic                     halted,
  output logic                     error,
  output state_t                   state
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    ir;
  logic [3:0]               opcode;
  logic [ADDRESS_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0]    operand_ext;

  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0]    ir_next;
  logic [DATA_WIDTH-1:0]    acc_next;
  logic                     zero_next;
  logic                     carry_next;
  logic                     halted_next;
  logic                     error_next;

  logic [ADDRESS_WIDTH-1:0] mar_c;
  logic [DATA_WIDTH-1:0]    wdata_c;
  logic                     wr_c;

  logic [DATA_WIDTH-1:0]    alu_m;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     alu_carry;
  logic                     alu_zero;
  logic                     alu_writes;

  assign opcode      = ir[DATA_WIDTH-1 -: 4];
  assign operand     = ir[ADDRESS_WIDTH-1:0];
  assign operand_ext = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, operand};

  // Memory ops see the RAM word in S_EXEC; register-only ops (LDI) finish
  // in S_DECODE and take the immediate operand instead.
  assign alu_m = (state == S_EXEC) ? ram.MDROut : operand_ext;

  avion_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .opcode     (opcode),
    .acc        (ACC),
    .m          (alu_m),
    .carry_in   (carry),
    .result     (alu_result),
    .carry_out  (alu_carry),
    .zero       (alu_zero),
    .writes_acc (alu_writes)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      PC     <= '0;
      ir     <= '0;
      ACC    <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      halted <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_next;
      PC     <= pc_next;
      ir     <= ir_next;
      ACC    <= acc_next;
      zero   <= zero_next;
      carry  <= carry_next;
      halted <= halted_next;
      error  <= error_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = PC;
    ir_next     = ir;
    acc_next    = ACC;
    zero_next   = zero;
    carry_next  = carry;
    halted_next = halted;
    error_next  = error;
    mar_c       = '0;
    wdata_c     = '0;
    wr_c        = 1'b0;
    case (state)
      S_FETCH: begin
        mar_c      = PC;
        state_next = S_LATCH;
      end
      S_LATCH: begin
        ir_next    = ram.MDROut;
        pc_next    = PC + PC_STEP;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_mem_op(opcode)) begin
          mar_c      = operand;
          state_next = S_EXEC;
        end else begin
          state_next = S_FETCH;
          // Jump tests use ACC as registered before this instruction, and
          // a taken jump overrides the increment done in S_LATCH.
          case (opcode)
            OP_JMP: pc_next = operand;
            OP_JMZ: if (ACC == '0) pc_next = operand;
            OP_JMN: if (ACC[DATA_WIDTH-1]) pc_next = operand;
            OP_HLT: begin
              state_next  = S_HALT;
              halted_next = 1'b1;
            end
            OP_ILL: begin
              state_next  = S_HALT;
              halted_next = 1'b1;
              error_next  = 1'b1;
            end
            default: ;
          endcase
          if (alu_writes) begin
            acc_next   = alu_result;
            zero_next  = alu_zero;
            carry_next = alu_carry;
          end
        end
      end
      S_EXEC: begin
        state_next = S_FETCH;
        if (opcode == OP_STO) begin
          mar_c   = operand;
          wdata_c = ACC;
          wr_c    = 1'b1;
        end else if (alu_writes) begin
          acc_next   = alu_result;
          zero_next  = alu_zero;
          carry_next = alu_carry;
        end
      end
      S_HALT: ;
      default: state_next = S_FETCH;
    endcase
  end

  // Bus outputs are forced low during reset so a reset landing on a STO's
  // S_EXEC cycle cannot commit the write.
  assign ram.MAR   = rst ? '0 : mar_c;
  assign ram.MDRIn = rst ? '0 : wdata_c;
  assign ram.RAMWr = rst ? 1'b0 : wr_c;

endmodule

// File: tb/tb_avion_cpu_v2.sv
// tb_avion_cpu_v2: directed self-checking bench for avion_cpu_v2.
// Two cores: a default 6/10 instance and an 8/12 instance for the PC-wrap
// run. Each has a behavioural single-port RAM with a load port.
module tb_avion_cpu_v2;
  import avion_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_w;

  // ---------------- default instance ----------------
  avion_cpu_v2_if #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) ram_if ();
  logic [5:0] pc;
  logic [9:0] acc;
  logic       zero, carry, halted, error;
  state_t     dbg_state;

  avion_cpu_v2 #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .ram    (ram_if.master),
    .PC     (pc),
    .ACC    (acc),
    .zero   (zero),
    .carry  (carry),
    .halted (halted),
    .error  (error),
    .state  (dbg_state)
  );

  logic [9:0] mem [64];
  logic [9:0] img [64];
  logic [9:0] rdata;
  logic       load_en;
  logic [5:0] load_addr;
  logic [9:0] load_data;
  int         wr_count = 0;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (ram_if.RAMWr === 1'b1) mem[ram_if.MAR] <= ram_if.MDRIn;
    rdata <= mem[ram_if.MAR];
    if (ram_if.RAMWr === 1'b1) wr_count <= wr_count + 1;
  end
  assign ram_if.MDROut = rdata;

  // ---------------- wide instance ----------------
  avion_cpu_v2_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(12)) ram_if_w ();
  logic [7:0]  pc_w;
  logic [11:0] acc_w;
  logic        zero_w, carry_w, halted_w, error_w;
  state_t      dbg_state_w;

  avion_cpu_v2 #(.ADDRESS_WIDTH(8), .DATA_WIDTH(12)) u_wide (
    .clk    (clk),
    .rst    (rst_w),
    .ram    (ram_if_w.master),
    .PC     (pc_w),
    .ACC    (acc_w),
    .zero   (zero_w),
    .carry  (carry_w),
    .halted (halted_w),
    .error  (error_w),
    .state  (dbg_state_w)
  );

  logic [11:0] mem_w [256];
  logic [11:0] img_w [256];
  logic [11:0] rdata_w;
  logic        load_en_w;
  logic [7:0]  load_addr_w;
  logic [11:0] load_data_w;
  logic [7:0]  pc_w_prev;
  logic        wrap_seen = 1'b0;

  always @(posedge clk) begin
    if (load_en_w) mem_w[load_addr_w] <= load_data_w;
    else if (ram_if_w.RAMWr === 1'b1) mem_w[ram_if_w.MAR] <= ram_if_w.MDRIn;
    rdata_w <= mem_w[ram_if_w.MAR];
  end
  assign ram_if_w.MDROut = rdata_w;

  always @(negedge clk) begin
    if (rst_w === 1'b0 && pc_w_prev == 8'd255 && pc_w == 8'd0) wrap_seen <= 1'b1;
    pc_w_prev <= pc_w;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_val(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [9:0] w(input logic [3:0] op, input logic [5:0] a);
    return {op, a};
  endfunction

  function automatic logic [11:0] w12(input logic [3:0] op, input logic [7:0] a);
    return {op, a};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = '0;
  endtask

  // Holds the core in reset while the image is copied into RAM.
  task automatic load_image();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      load_addr = 6'(i);
      load_data = img[i];
      load_en   = 1'b1;
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic run_prog(input int limit, output int cycles);
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    while (halted !== 1'b1 && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  int cyc;
  int wr_before;
  logic found;

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    load_en_w = 1'b0; load_addr_w = '0; load_data_w = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    expect_val(0); expect_val(0); expect_val(0); expect_val(0);
    expect_val(0); expect_val(0); expect_val(0); expect_val(0);
    expect_val(16'(S_FETCH));
    check("rst_pc", 16'(pc));
    check("rst_acc", 16'(acc));
    check("rst_flags", {12'd0, zero, carry, halted, error});
    check("rst_mar", 16'(ram_if.MAR));
    check("rst_wr", 16'(ram_if.RAMWr));
    check("rst_mdrin", 16'(ram_if.MDRIn));
    check("rst_pc_w", 16'(pc_w));
    check("rst_halted_w", 16'(halted_w));
    check("rst_state", 16'(dbg_state));

    // Test 1: LOD 50, ADD 51, STO 52, HLT
    clear_img();
    img[0] = w(OP_LOD, 50); img[1] = w(OP_ADD, 51);
    img[2] = w(OP_STO, 52); img[3] = w(OP_HLT, 0);
    img[50] = 10'd5; img[51] = 10'd10;
    load_image();
    expect_val(15); expect_val(1); expect_val(0); expect_val(15);
    expect_val(15); expect_val(4); expect_val(16'(S_HALT));
    run_prog(100, cyc);
    check("t1_cycles", 16'(cyc));
    check("t1_halted", 16'(halted));
    check("t1_error", 16'(error));
    check("t1_mem52", 16'(mem[52]));
    check("t1_acc", 16'(acc));
    check("t1_pc", 16'(pc));
    check("t1_state", 16'(dbg_state));

    // Test 2: same with MUL
    img[1] = w(OP_MUL, 51);
    load_image();
    expect_val(50); expect_val(15);
    run_prog(100, cyc);
    check("t2_mem52", 16'(mem[52]));
    check("t2_cycles", 16'(cyc));

    // Test 3: countdown loop, JMZ not taken twice then taken
    clear_img();
    img[0] = w(OP_LOD, 51); img[1] = w(OP_SUB, 49); img[2] = w(OP_STO, 51);
    img[3] = w(OP_JMZ, 10); img[4] = w(OP_JMP, 0);
    img[10] = w(OP_LOD, 50); img[11] = w(OP_STO, 52); img[12] = w(OP_HLT, 0);
    img[49] = 10'd1; img[50] = 10'd50; img[51] = 10'd3;
    load_image();
    expect_val(50); expect_val(0); expect_val(13); expect_val(62);
    run_prog(500, cyc);
    check("t3_mem52", 16'(mem[52]));
    check("t3_mem51", 16'(mem[51]));
    check("t3_pc", 16'(pc));
    check("t3_cycles", 16'(cyc));

    // Test 4a: 1023 + 2 wraps with carry
    clear_img();
    img[0] = w(OP_LOD, 50); img[1] = w(OP_ADD, 51); img[2] = w(OP_HLT, 0);
    img[49] = 10'd1; img[50] = 10'd1023; img[51] = 10'd2;
    load_image();
    expect_val(1); expect_val(1); expect_val(0); expect_val(11);
    run_prog(100, cyc);
    check("t4_acc", 16'(acc));
    check("t4_carry", 16'(carry));
    check("t4_zero", 16'(zero));
    check("t4_cycles", 16'(cyc));

    // Test 4b: ... then SUB 1 gives zero, no borrow
    img[2] = w(OP_SUB, 49); img[3] = w(OP_HLT, 0);
    load_image();
    expect_val(0); expect_val(1); expect_val(0);
    run_prog(100, cyc);
    check("t4b_acc", 16'(acc));
    check("t4b_zero", 16'(zero));
    check("t4b_carry", 16'(carry));

    // Test 5a: ACC=0x200, JMN taken, SHL shifts MSB into carry
    clear_img();
    img[0] = w(OP_LOD, 50); img[1] = w(OP_JMN, 5); img[2] = w(OP_HLT, 0);
    img[5] = w(OP_SHL, 0);  img[6] = w(OP_HLT, 0);
    img[50] = 10'h200;
    load_image();
    expect_val(7); expect_val(0); expect_val(1); expect_val(1); expect_val(13);
    run_prog(100, cyc);
    check("t5_pc", 16'(pc));
    check("t5_acc", 16'(acc));
    check("t5_carry", 16'(carry));
    check("t5_zero", 16'(zero));
    check("t5_cycles", 16'(cyc));

    // Test 5b: LDI 7, SHR
    clear_img();
    img[0] = w(OP_LDI, 7); img[1] = w(OP_SHR, 0); img[2] = w(OP_HLT, 0);
    load_image();
    expect_val(3); expect_val(1); expect_val(0); expect_val(9);
    run_prog(100, cyc);
    check("t5b_acc", 16'(acc));
    check("t5b_carry", 16'(carry));
    check("t5b_zero", 16'(zero));
    check("t5b_cycles", 16'(cyc));

    // Test 6: illegal opcode at address 0
    clear_img();
    img[0] = w(OP_ILL, 0);
    load_image();
    wr_before = wr_count;
    expect_val(3); expect_val(1); expect_val(1); expect_val(0);
    expect_val(1); expect_val(16'(S_HALT));
    run_prog(100, cyc);
    repeat (5) @(posedge clk);
    #1;
    check("t6_cycles", 16'(cyc));
    check("t6_error", 16'(error));
    check("t6_halted", 16'(halted));
    check("t6_writes", 16'(wr_count - wr_before));
    check("t6_pc_held", 16'(pc));
    check("t6_state", 16'(dbg_state));

    // Test 7: reset during STO's write cycle
    clear_img();
    img[0] = w(OP_LDI, 7); img[1] = w(OP_STO, 52); img[2] = w(OP_HLT, 0);
    img[52] = 10'd123;
    load_image();
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ram_if.RAMWr === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    #1;
    expect_val(1); expect_val(0); expect_val(0); expect_val(0);
    check("t7_wr_seen", 16'(found));
    check("t7_wr_in_rst", 16'(ram_if.RAMWr));
    check("t7_mar_in_rst", 16'(ram_if.MAR));
    check("t7_mdrin_in_rst", 16'(ram_if.MDRIn));
    @(posedge clk);
    #1;
    expect_val(0); expect_val(0); expect_val(0); expect_val(123); expect_val(16'(S_FETCH));
    check("t7_pc", 16'(pc));
    check("t7_acc", 16'(acc));
    check("t7_flags", {12'd0, zero, carry, halted, error});
    check("t7_mem52", 16'(mem[52]));
    check("t7_state", 16'(dbg_state));
    expect_val(7); expect_val(10);
    run_prog(100, cyc);
    check("t7_rerun_mem52", 16'(mem[52]));
    check("t7_rerun_cycles", 16'(cyc));
    rst = 1'b1;

    // Test 8: 8/12 core, program 1 spread across the PC wrap
    for (int i = 0; i < 256; i++) img_w[i] = '0;
    img_w[0]   = w12(OP_JMP, 249);
    img_w[249] = w12(OP_LOD, 50);
    img_w[250] = w12(OP_ADD, 51);
    img_w[251] = w12(OP_STO, 52);
    img_w[252] = w12(OP_LOD, 60);
    img_w[253] = w12(OP_STO, 0);
    img_w[254] = w12(OP_NOP, 0);
    img_w[255] = w12(OP_NOP, 0);
    img_w[50]  = 12'd5;
    img_w[51]  = 12'd10;
    img_w[60]  = w12(OP_HLT, 0);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      load_addr_w = 8'(i);
      load_data_w = img_w[i];
      load_en_w   = 1'b1;
      @(negedge clk);
    end
    load_en_w = 1'b0;
    @(negedge clk);
    rst_w = 1'b0;
    cyc = 0;
    while (halted_w !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    expect_val(15); expect_val(1); expect_val(0); expect_val(1);
    expect_val(1); expect_val(32); expect_val(16'h900);
    check("t8_mem52", 16'(mem_w[52]));
    check("t8_halted", 16'(halted_w));
    check("t8_error", 16'(error_w));
    check("t8_wrap_seen", 16'(wrap_seen));
    check("t8_pc", 16'(pc_w));
    check("t8_cycles", 16'(cyc));
    check("t8_acc", 16'(acc_w));

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
